// File: rtl/serv_seq.sv
`default_nettype none
// ============================================================================
//  Module   : serv_seq
//  Purpose  : Sequencer for the bit-serial core datapath. Handles the
//             instruction-fetch and data-bus handshakes and owns the serial
//             bit counter that steps the datapath one bit per cycle, for one
//             pass (single-stage) or two passes (init + final, with an
//             optional memory wait in between).
//  Options  : SERV_SEQ_TIMEOUT_EN - bus-ack timeout with o_bus_err pulse
//  Revision : 1.0 - initial release
// ============================================================================
module serv_seq #(
    parameter int CNT_W   = 5,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             i_rst,
    output logic             o_ibus_cyc,
    input  logic             i_ibus_ack,
    input  logic             i_two_stage,
    input  logic             i_mem_op,
    output logic             o_dbus_cyc,
    input  logic             i_dbus_ack,
    output logic             o_cnt_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_cnt0,
    output logic             o_cnt_done,
    output logic             o_init,
    output logic             o_pc_en,
    output logic             o_bus_err
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_RUN    = 2'd2,
        S_MEM    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ibus_cyc, w_ibus_nxt;
    logic             r_dbus_cyc, w_dbus_nxt;
    logic             r_init,     w_init_nxt;
    logic [CNT_W-1:0] r_cnt,      w_cnt_nxt;
    logic             r_ts,       w_ts_nxt;
    logic             r_mo,       w_mo_nxt;
    logic             w_cnt_en;
    logic             w_decoded_ts;
    logic             w_tmo_hit;

    // A memory operation always needs the init pass before the bus access.
    assign w_decoded_ts = i_two_stage | i_mem_op;

`ifdef SERV_SEQ_TIMEOUT_EN
    // The counter value seen in the Nth cycle of an un-acked request is N-1,
    // so the limit is reached in the TIMEOUT-th waiting cycle.
    localparam logic [7:0] c_TMO_LIM = 8'(TIMEOUT - 1);

    logic [7:0] r_tmo;
    logic       r_bus_err;
    logic       w_cyc_any;
    logic       w_ack_any;

    assign w_cyc_any = r_ibus_cyc | r_dbus_cyc;
    assign w_ack_any = (r_ibus_cyc & i_ibus_ack) | (r_dbus_cyc & i_dbus_ack);
    // An ack in the limit cycle wins over the timeout.
    assign w_tmo_hit = w_cyc_any & ~w_ack_any & (r_tmo == c_TMO_LIM);
    assign o_bus_err = r_bus_err;

    // Wait counter: idle at zero while no request is open, so a rising cyc
    // always starts from zero; error pulse is registered for one cycle.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_tmo     <= 8'd0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= w_tmo_hit;
            if (!w_cyc_any || w_ack_any || w_tmo_hit) begin
                r_tmo <= 8'd0;
            end else begin
                r_tmo <= r_tmo + 8'd1;
            end
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    // Sequencer state register and all registered control outputs.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_FETCH;
            r_ibus_cyc <= 1'b0;
            r_dbus_cyc <= 1'b0;
            r_init     <= 1'b0;
            r_cnt      <= c_CNT_ZERO;
            r_ts       <= 1'b0;
            r_mo       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ibus_cyc <= w_ibus_nxt;
            r_dbus_cyc <= w_dbus_nxt;
            r_init     <= w_init_nxt;
            r_cnt      <= w_cnt_nxt;
            r_ts       <= w_ts_nxt;
            r_mo       <= w_mo_nxt;
        end
    end

    // Next-state, handshake and counter control.
    always_comb begin
        w_state_nxt = r_state;
        w_ibus_nxt  = r_ibus_cyc;
        w_dbus_nxt  = r_dbus_cyc;
        w_init_nxt  = r_init;
        w_cnt_nxt   = r_cnt;
        w_ts_nxt    = r_ts;
        w_mo_nxt    = r_mo;
        w_cnt_en    = 1'b0;

        case (r_state)
            S_FETCH: begin
                if (!r_ibus_cyc) begin
                    w_ibus_nxt = 1'b1;
                end else if (i_ibus_ack) begin
                    w_ibus_nxt  = 1'b0;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_ts_nxt    = w_decoded_ts;
                w_mo_nxt    = i_mem_op;
                w_init_nxt  = w_decoded_ts;
                w_cnt_nxt   = c_CNT_ZERO;
                w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_cnt_en  = 1'b1;
                // Natural wrap brings the counter back to zero after the last bit.
                w_cnt_nxt = r_cnt + c_CNT_ONE;
                if (r_cnt == c_CNT_MAX) begin
                    if (r_init) begin
                        w_init_nxt = 1'b0;
                        if (r_mo) begin
                            w_dbus_nxt  = 1'b1;
                            w_state_nxt = S_MEM;
                        end
                    end else begin
                        // Raise the next fetch on the same edge to save a cycle.
                        w_ibus_nxt  = 1'b1;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_MEM: begin
                w_cnt_nxt = c_CNT_ZERO;
                if (r_dbus_cyc && i_dbus_ack) begin
                    w_dbus_nxt  = 1'b0;
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_FETCH;
            end
        endcase

        // Timeout abandons the current instruction and refetches.
        if (w_tmo_hit) begin
            w_ibus_nxt  = 1'b0;
            w_dbus_nxt  = 1'b0;
            w_init_nxt  = 1'b0;
            w_cnt_nxt   = c_CNT_ZERO;
            w_state_nxt = S_FETCH;
        end
    end

    assign o_ibus_cyc = r_ibus_cyc;
    assign o_dbus_cyc = r_dbus_cyc;
    assign o_init     = r_init;
    assign o_cnt      = r_cnt;
    assign o_cnt_en   = w_cnt_en;
    assign o_cnt0     = w_cnt_en & (r_cnt == c_CNT_ZERO);
    assign o_cnt_done = w_cnt_en & (r_cnt == c_CNT_MAX);
    assign o_pc_en    = w_cnt_en & ~r_init;

endmodule
`default_nettype wire
